keyexp_ctrl: RTL and testbench

Sequencer for the byte-serial AES-128 key-expansion datapath. It steps the datapath through a 16-cycle key load and then ten 16-cycle expansion rounds. Every cycle it drives the datapath's mux selects, round index and Rcon enable, and it gives the surrounding cipher controller a start/done handshake plus round-key strobes. It sits between the top-level AES controller and the key-expansion datapath. It owns no key data.

---
 rtl/keyexp_ctrl_if.sv | 56 +++++
 rtl/keyexp_ctrl.sv | 153 +++++++++++++++
 tb/tb_keyexp_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/keyexp_ctrl_if.sv
// keyexp_ctrl_if
// Bundles the start/done handshake, the datapath select lines and the
// round-key strobes between the AES controller, keyexp_ctrl and the
// byte-serial key-expansion datapath.
//   start        cipher controller -> keyexp_ctrl, request a key schedule
//   abort        cipher controller -> keyexp_ctrl, only with KEYEXP_CTRL_ABORT_EN
//   key_req      external key byte must be on the datapath key input
//   input_sel    1 = load external key byte, 0 = recirculate
//   sbox_sel     1 = S-box fed from saved RotWord byte, 0 = shift-register tap
//   xor_sel      1 = word-chaining XOR at mid tap
//   last_sel     1 = S-box/Rcon XOR at output tap
//   round_count  expansion round 0..9
//   rcon_en      8'hFF on the first byte of a round
//   rk_valid     round-key byte leaving the datapath
//   rk_round     round-key index 1..10
//   busy         LOAD or EXPAND in progress
//   done         one-cycle completion pulse
// Macro: KEYEXP_CTRL_ABORT_EN adds the abort signal.

interface keyexp_ctrl_if;
    logic       start;
`ifdef KEYEXP_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       key_req;
    logic       input_sel;
    logic       sbox_sel;
    logic       xor_sel;
    logic       last_sel;
    logic [3:0] round_count;
    logic [7:0] rcon_en;
    logic       rk_valid;
    logic [3:0] rk_round;
    logic       busy;
    logic       done;

    // Cipher-controller side
    modport master (
        output start,
`ifdef KEYEXP_CTRL_ABORT_EN
        output abort,
`endif
        input  key_req, input_sel, sbox_sel, xor_sel, last_sel,
        input  round_count, rcon_en, rk_valid, rk_round, busy, done
    );

    // Sequencer side
    modport slave (
        input  start,
`ifdef KEYEXP_CTRL_ABORT_EN
        input  abort,
`endif
        output key_req, input_sel, sbox_sel, xor_sel, last_sel,
        output round_count, rcon_en, rk_valid, rk_round, busy, done
    );
endinterface

// File: rtl/keyexp_ctrl.sv
// keyexp_ctrl
// Sequencer for the byte-serial AES-128 key-expansion datapath: a 16-cycle
// key load followed by ten 16-cycle expansion rounds, then a one-cycle DONE.
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     keyexp_ctrl_if.slave (handshake, selects, round-key strobes)
// Macro: KEYEXP_CTRL_ABORT_EN enables bus.abort (return to IDLE from any
// active state; abort beats start in IDLE).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, all outputs 0
// LOAD   | 16 cycles shifting the external key bytes in
// EXPAND | 10 rounds x 16 cycles, round-key bytes leaving the datapath
// DONE   | single cycle, done pulse; start here restarts immediately

module keyexp_ctrl (
    input  logic           i_clk,
    input  logic           i_rst,
    keyexp_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_byte;
    logic [3:0] r_round;

    state_t     w_state_nxt;
    logic [3:0] w_byte_nxt;
    logic [3:0] w_round_nxt;
    logic       w_abort;

`ifdef KEYEXP_CTRL_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_byte  <= 4'd0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
            r_round <= w_round_nxt;
        end
    end

    // Counters are cleared whenever the FSM leaves an active state so that
    // IDLE/DONE always sit at c=0, r=0.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_round_nxt = r_round;
        case (r_state)
            S_IDLE: begin
                w_byte_nxt  = 4'd0;
                w_round_nxt = 4'd0;
                if (bus.start && !w_abort)
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_byte_nxt  = 4'd0;
                end else if (r_byte == 4'd15) begin
                    w_state_nxt = S_EXPAND;
                    w_byte_nxt  = 4'd0;
                    w_round_nxt = 4'd0;
                end else begin
                    w_byte_nxt  = r_byte + 4'd1;
                end
            end
            S_EXPAND: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_byte_nxt  = 4'd0;
                    w_round_nxt = 4'd0;
                end else if (r_byte == 4'd15) begin
                    w_byte_nxt = 4'd0;
                    if (r_round == 4'd9) begin
                        w_state_nxt = S_DONE;
                        w_round_nxt = 4'd0;
                    end else begin
                        w_round_nxt = r_round + 4'd1;
                    end
                end else begin
                    w_byte_nxt = r_byte + 4'd1;
                end
            end
            S_DONE: begin
                w_byte_nxt  = 4'd0;
                w_round_nxt = 4'd0;
                if (bus.start && !w_abort)
                    w_state_nxt = S_LOAD;
                else
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = 4'd0;
                w_round_nxt = 4'd0;
            end
        endcase
    end

    // Moore output decode from registers only.
    always_comb begin
        bus.key_req     = 1'b0;
        bus.input_sel   = 1'b0;
        bus.sbox_sel    = 1'b0;
        bus.xor_sel     = 1'b0;
        bus.last_sel    = 1'b0;
        bus.round_count = 4'd0;
        bus.rcon_en     = 8'h00;
        bus.rk_valid    = 1'b0;
        bus.rk_round    = 4'd0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.key_req   = 1'b1;
                bus.input_sel = 1'b1;
                bus.busy      = 1'b1;
            end
            S_EXPAND: begin
                bus.last_sel    = (r_byte <= 4'd3);
                bus.sbox_sel    = (r_byte == 4'd3);
                bus.xor_sel     = (r_byte >= 4'd12);
                bus.rcon_en     = (r_byte == 4'd0) ? 8'hFF : 8'h00;
                bus.round_count = r_round;
                bus.rk_valid    = 1'b1;
                bus.rk_round    = r_round + 4'd1;
                bus.busy        = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_keyexp_ctrl.sv
module tb_keyexp_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [23:0] sb_q[$];

    keyexp_ctrl_if bus ();

    keyexp_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected output vector for cycle k of a schedule whose start was
    // sampled at edge 0.  Layout:
    // {key_req,input_sel,sbox_sel,xor_sel,last_sel,round_count,rcon_en,
    //  rk_valid,rk_round,busy,done}
    function automatic logic [23:0] model(int k);
        logic       kr, is, sb, xs, ls, rv, by, dn;
        logic [3:0] rc, rr, c;
        logic [7:0] rcon;
        int         t;
        kr = 0; is = 0; sb = 0; xs = 0; ls = 0; rv = 0; by = 0; dn = 0;
        rc = 0; rr = 0; rcon = 0; c = 0;
        if (k >= 1 && k <= 16) begin
            kr = 1; is = 1; by = 1;
        end else if (k >= 17 && k <= 176) begin
            t    = k - 17;
            c    = 4'(t % 16);
            rc   = 4'(t / 16);
            rr   = 4'(t / 16 + 1);
            ls   = (c < 4);
            sb   = (c == 3);
            xs   = (c >= 12);
            rcon = (c == 0) ? 8'hFF : 8'h00;
            rv   = 1; by = 1;
        end else if (k == 177) begin
            dn = 1;
        end
        return {kr, is, sb, xs, ls, rc, rcon, rv, rr, by, dn};
    endfunction

    function automatic logic [23:0] observed();
        return {bus.key_req, bus.input_sel, bus.sbox_sel, bus.xor_sel,
                bus.last_sel, bus.round_count, bus.rcon_en, bus.rk_valid,
                bus.rk_round, bus.busy, bus.done};
    endfunction

    task automatic push_sched();
        for (int k = 1; k <= 177; k++) sb_q.push_back(model(k));
    endtask

    task automatic push_partial(int n);
        for (int k = 1; k <= n; k++) sb_q.push_back(model(k));
    endtask

    task automatic push_idle(int n);
        for (int k = 0; k < n; k++) sb_q.push_back(24'h0);
    endtask

    // Advance one clock, then compare the DUT against the next scoreboard entry.
    task automatic step(string tag);
        logic [23:0] exp_v, obs_v;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s cyc=%0d scoreboard empty", tag, cyc);
        end else begin
            exp_v = sb_q.pop_front();
            obs_v = observed();
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic step_n(int n, string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
`ifdef KEYEXP_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        @(posedge clk);
        #1;
        push_idle(2);
        step_n(2, "reset");
        rst = 1'b0;
        push_idle(2);
        step_n(2, "idle");

        // Nominal schedule with start pulses sprinkled through EXPAND.
        bus.start = 1'b1;
        push_sched();
        push_idle(3);
        step("nominal");
        bus.start = 1'b0;
        step_n(48, "nominal");
        bus.start = 1'b1;
        step("nominal_startpulse");
        bus.start = 1'b0;
        step_n(49, "nominal");
        bus.start = 1'b1;
        step("nominal_startpulse");
        bus.start = 1'b0;
        step_n(80, "nominal");

        // start held high: back-to-back schedules, second LOAD at cycle 178.
        bus.start = 1'b1;
        push_sched();
        push_partial(85);
        step_n(177, "held_first");
        step_n(85, "held_second");
        bus.start = 1'b0;

        // Reset for 3 cycles in the middle of round 4.
        rst = 1'b1;
        push_idle(3);
        step_n(3, "midreset");
        rst = 1'b0;
        push_idle(2);
        step_n(2, "postreset_idle");
        bus.start = 1'b1;
        push_sched();
        push_idle(2);
        step("after_reset");
        bus.start = 1'b0;
        step_n(178, "after_reset");

`ifdef KEYEXP_CTRL_ABORT_EN
        // Abort in cycle 40, new start in cycle 50.
        bus.start = 1'b1;
        push_sched();
        step("abort_run");
        bus.start = 1'b0;
        step_n(39, "abort_run");
        bus.abort = 1'b1;
        sb_q.delete();
        push_idle(10);
        step("abort_idle");
        bus.abort = 1'b0;
        step_n(9, "abort_idle");
        bus.start = 1'b1;
        push_sched();
        push_idle(1);
        step("restart");
        bus.start = 1'b0;
        step_n(177, "restart");

        // abort wins over start in IDLE.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        push_idle(3);
        step("abort_start_idle");
        bus.abort = 1'b0;
        bus.start = 1'b0;
        step_n(2, "abort_start_idle");
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL leftover entries=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
